// File: rtl/seg_time_decoder.sv
// Receive-side monitor for a 24-hour seven-segment clock: decodes sampled digits,
// flags illegal patterns and impossible times, and tracks one-minute advancement.
module seg_time_decoder #(
  parameter int unsigned LOCK_COUNT = 2,
  parameter int unsigned ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample,
  input  logic [6:0]       sh1,
  input  logic [6:0]       sh0,
  input  logic [6:0]       sm1,
  input  logic [6:0]       sm0,
  output logic [3:0]       h1,
  output logic [3:0]       h0,
  output logic [3:0]       m1,
  output logic [3:0]       m0,
  output logic             bad_seg,
  output logic             bad_time,
  output logic             seq_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned MCNT_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {S_UNLOCKED, S_ARMED, S_TRACK} state_t;

  // Segment order {a,b,c,d,e,f,g}; anything outside the ten digit glyphs is F.
  function automatic logic [3:0] seg_dec(input logic [6:0] s);
    case (s)
      7'b1111110: seg_dec = 4'd0;
      7'b0110000: seg_dec = 4'd1;
      7'b1101101: seg_dec = 4'd2;
      7'b1111001: seg_dec = 4'd3;
      7'b0110011: seg_dec = 4'd4;
      7'b1011011: seg_dec = 4'd5;
      7'b1011111: seg_dec = 4'd6;
      7'b1110000: seg_dec = 4'd7;
      7'b1111111: seg_dec = 4'd8;
      7'b1111011: seg_dec = 4'd9;
      default:    seg_dec = 4'hF;
    endcase
  endfunction

  // BCD HH:MM plus one minute, 23:59 wrapping to 00:00.
  function automatic logic [15:0] next_time(input logic [15:0] t);
    logic [3:0] th1, th0, tm1, tm0;
    {th1, th0, tm1, tm0} = t;
    if (tm0 != 4'd9) begin
      tm0 = tm0 + 4'd1;
    end else begin
      tm0 = 4'd0;
      if (tm1 != 4'd5) begin
        tm1 = tm1 + 4'd1;
      end else begin
        tm1 = 4'd0;
        if (th1 == 4'd2 && th0 == 4'd3) begin
          th1 = 4'd0;
          th0 = 4'd0;
        end else if (th0 == 4'd9) begin
          th0 = 4'd0;
          th1 = th1 + 4'd1;
        end else begin
          th0 = th0 + 4'd1;
        end
      end
    end
    next_time = {th1, th0, tm1, tm0};
  endfunction

  state_t             r_state, w_state_nx;
  logic [MCNT_W-1:0]  r_mcnt, w_mcnt_nx, w_mcnt_inc;
  logic [15:0]        r_time, w_time_nx;
  logic [15:0]        r_prev, w_prev_nx;
  logic               r_bad_seg, w_bad_seg_nx;
  logic               r_bad_time, w_bad_time_nx;
  logic               r_seq_err, w_seq_err_nx;
  logic               r_locked;
  logic [ERR_W-1:0]   r_err, w_err_nx;

  logic [3:0]  w_h1, w_h0, w_m1, w_m0;
  logic [15:0] w_cur, w_exp;
  logic        w_seg_ok, w_range_ok, w_valid, w_match;

  assign w_h1       = seg_dec(sh1);
  assign w_h0       = seg_dec(sh0);
  assign w_m1       = seg_dec(sm1);
  assign w_m0       = seg_dec(sm0);
  assign w_cur      = {w_h1, w_h0, w_m1, w_m0};
  assign w_seg_ok   = (w_h1 != 4'hF) && (w_h0 != 4'hF) && (w_m1 != 4'hF) && (w_m0 != 4'hF);
  assign w_range_ok = (w_h1 <= 4'd2) && !(w_h1 == 4'd2 && w_h0 > 4'd3) && (w_m1 <= 4'd5);
  assign w_valid    = w_seg_ok && w_range_ok;
  assign w_exp      = next_time(r_prev);
  assign w_match    = (w_cur == w_exp);
  assign w_mcnt_inc = r_mcnt + MCNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_UNLOCKED;
      r_mcnt     <= '0;
      r_time     <= '0;
      r_prev     <= '0;
      r_bad_seg  <= 1'b0;
      r_bad_time <= 1'b0;
      r_seq_err  <= 1'b0;
      r_locked   <= 1'b0;
      r_err      <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_mcnt     <= w_mcnt_nx;
      r_time     <= w_time_nx;
      r_prev     <= w_prev_nx;
      r_bad_seg  <= w_bad_seg_nx;
      r_bad_time <= w_bad_time_nx;
      r_seq_err  <= w_seq_err_nx;
      r_locked   <= (w_state_nx == S_TRACK);
      r_err      <= w_err_nx;
    end
  end

  // Lock FSM and flag generation; nothing moves without a sample strobe.
  always_comb begin
    w_state_nx    = r_state;
    w_mcnt_nx     = r_mcnt;
    w_time_nx     = r_time;
    w_prev_nx     = r_prev;
    w_bad_seg_nx  = 1'b0;
    w_bad_time_nx = 1'b0;
    w_seq_err_nx  = 1'b0;
    w_err_nx      = r_err;
    if (sample) begin
      w_time_nx     = w_cur;
      w_bad_seg_nx  = !w_seg_ok;
      w_bad_time_nx = w_seg_ok && !w_range_ok;
      if (w_valid) w_prev_nx = w_cur;
      case (r_state)
        S_UNLOCKED: begin
          if (w_valid) begin
            w_state_nx = S_ARMED;
            w_mcnt_nx  = '0;
          end
        end
        S_ARMED: begin
          if (!w_valid) begin
            w_state_nx = S_UNLOCKED;
            w_mcnt_nx  = '0;
          end else if (w_match) begin
            w_mcnt_nx = w_mcnt_inc;
            if (w_mcnt_inc == MCNT_W'(LOCK_COUNT)) w_state_nx = S_TRACK;
          end else begin
            w_mcnt_nx = '0;
          end
        end
        S_TRACK: begin
          if (!w_valid) begin
            w_state_nx = S_UNLOCKED;
            w_mcnt_nx  = '0;
          end else if (!w_match) begin
            w_seq_err_nx = 1'b1;
            w_state_nx   = S_ARMED;
            w_mcnt_nx    = '0;
          end
        end
        default: begin
          w_state_nx = S_UNLOCKED;
          w_mcnt_nx  = '0;
        end
      endcase
      if ((w_bad_seg_nx || w_bad_time_nx || w_seq_err_nx) && (r_err != {ERR_W{1'b1}}))
        w_err_nx = r_err + ERR_W'(1);
    end
  end

  assign {h1, h0, m1, m0} = r_time;
  assign bad_seg   = r_bad_seg;
  assign bad_time  = r_bad_time;
  assign seq_err   = r_seq_err;
  assign locked    = r_locked;
  assign err_count = r_err;

endmodule

// File: tb/tb_seg_time_decoder.sv
// Scoreboard bench for seg_time_decoder: expected outputs are queued with each
// stimulus cycle and compared one cycle later.
module tb_seg_time_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample = 1'b0;
  logic [6:0] sh1 = '0, sh0 = '0, sm1 = '0, sm0 = '0;
  logic [3:0] h1, h0, m1, m0;
  logic       bad_seg, bad_time, seq_err, locked;
  logic [7:0] err_count;

  seg_time_decoder #(.LOCK_COUNT(2), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .sample(sample),
    .sh1(sh1), .sh0(sh0), .sm1(sm1), .sm0(sm0),
    .h1(h1), .h0(h0), .m1(m1), .m0(m0),
    .bad_seg(bad_seg), .bad_time(bad_time), .seq_err(seq_err),
    .locked(locked), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] h1, h0, m1, m0;
    logic       bs, bt, se, lk;
    logic [7:0] ec;
  } obs_t;

  obs_t obs;
  assign obs = {h1, h0, m1, m0, bad_seg, bad_time, seq_err, locked, err_count};

  obs_t sb[$];
  int   checks = 0;
  int   failures = 0;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: seg = 7'b1111110;  1: seg = 7'b0110000;  2: seg = 7'b1101101;
      3: seg = 7'b1111001;  4: seg = 7'b0110011;  5: seg = 7'b1011011;
      6: seg = 7'b1011111;  7: seg = 7'b1110000;  8: seg = 7'b1111111;
      9: seg = 7'b1111011;  default: seg = 7'b0000000;
    endcase
  endfunction

  function automatic logic [27:0] segs_of(input int t);
    segs_of = {seg(t / 1000), seg((t / 100) % 10), seg((t / 10) % 10), seg(t % 10)};
  endfunction

  function automatic obs_t mk(input int t, input logic bs, input logic bt,
                              input logic se, input logic lk, input int ec);
    obs_t r;
    r.h1 = 4'(t / 1000);
    r.h0 = 4'((t / 100) % 10);
    r.m1 = 4'((t / 10) % 10);
    r.m0 = 4'(t % 10);
    r.bs = bs; r.bt = bt; r.se = se; r.lk = lk;
    r.ec = 8'(ec);
    return r;
  endfunction

  // One clock of stimulus; entered and left 1 time unit after a rising edge.
  task automatic drv(input logic [27:0] s, input logic samp, input obs_t e);
    {sh1, sh0, sm1, sm0} = s;
    sample = samp;
    sb.push_back(e);
    @(posedge clk);
    #1;
    sample = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #4;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL reset got %h exp %h", obs, obs_t'(0));
    end
    rst = 1'b0;
  endtask

  task automatic test_decode();
    obs_t e;
    do_reset();
    drv(segs_of(1234), 1'b1, mk(1234, 0, 0, 0, 0, 0));
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL decode_1234 got %h exp %h", obs, e);
    end
  endtask

  task automatic test_lock();
    int   tv[6] = '{0, 1, 2, 2358, 2359, 0};
    logic lk[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    obs_t e;
    for (int i = 0; i < 6; i++) begin
      if (i == 0 || i == 3) do_reset();
      drv(segs_of(tv[i]), 1'b1, mk(tv[i], 0, 0, 0, lk[i], 0));
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL lock[%0d] got %h exp %h", i, obs, e);
      end
    end
  endtask

  // Back-to-back samples; a skipped minute while locked, relock, then hold.
  task automatic test_back_to_back();
    int   tv[7] = '{957, 958, 959, 1001, 1002, 1003, 1234};
    logic sv[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic se[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic lk[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int   ec[7] = '{0, 0, 0, 1, 1, 1, 1};
    obs_t e;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drv(segs_of(tv[i]), sv[i], mk(sv[i] ? tv[i] : 1003, 0, 0, se[i], lk[i], ec[i]));
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL seq[%0d] got %h exp %h", i, obs, e);
      end
    end
  endtask

  task automatic test_armed_mismatch();
    int   tv[4] = '{500, 700, 701, 702};
    logic lk[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    obs_t e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drv(segs_of(tv[i]), 1'b1, mk(tv[i], 0, 0, 0, lk[i], 0));
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL armed[%0d] got %h exp %h", i, obs, e);
      end
    end
  endtask

  task automatic test_bad();
    logic [27:0] s;
    obs_t        x[6];
    logic [27:0] sv[6];
    obs_t        e;
    x[0] = mk(0, 0, 0, 0, 0, 0);    sv[0] = segs_of(0);
    x[1] = mk(1, 0, 0, 0, 0, 0);    sv[1] = segs_of(1);
    x[2] = mk(2, 0, 0, 0, 1, 0);    sv[2] = segs_of(2);
    s = segs_of(3);
    s[6:0] = 7'b0000001;
    x[3] = mk(0, 1, 0, 0, 0, 1);    x[3].m0 = 4'hF;  sv[3] = s;
    x[4] = mk(2400, 0, 1, 0, 0, 2); sv[4] = segs_of(2400);
    x[5] = mk(2360, 0, 1, 0, 0, 3); sv[5] = segs_of(2360);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drv(sv[i], 1'b1, x[i]);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL bad[%0d] got %h exp %h", i, obs, e);
      end
    end
  endtask

  task automatic test_saturate();
    obs_t e;
    obs_t x;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      x = {16'hFFFF, 4'b1000, 8'((i + 1 > 255) ? 255 : i + 1)};
      drv(28'h0, 1'b1, x);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL sat[%0d] got %h exp %h", i, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t e;
    do_reset();
    drv(segs_of(0), 1'b1, mk(0, 0, 0, 0, 0, 0));
    void'(sb.pop_front());
    drv(segs_of(1), 1'b1, mk(1, 0, 0, 0, 0, 0));
    void'(sb.pop_front());
    drv(segs_of(2), 1'b1, mk(2, 0, 0, 0, 1, 0));
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL premid_lock got %h exp %h", obs, e);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL mid_reset got %h exp %h", obs, obs_t'(0));
    end
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    drv(segs_of(3), 1'b1, mk(3, 0, 0, 0, 0, 0));
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL post_reset got %h exp %h", obs, e);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_lock();
    test_back_to_back();
    test_armed_mismatch();
    test_bad();
    test_saturate();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
